// File: rtl/rst_seq_pkg.sv
// ============================================================================
// rst_seq_pkg : shared state encoding, default parameters and sizing helper
//               for the reset sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        SEQ  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_NUM_OUT     = 4;
    localparam int DEF_MIN_HOLD    = 8;
    localparam int DEF_STAGE_GAP   = 4;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rst_sync_chain.sv
// ============================================================================
// rst_sync_chain : async-assert / sync-release reset synchronizer.
// Rev 1.0
// ============================================================================
`default_nettype none

module rst_sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST_IN,
    output logic SYNC_OUT
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge CLK or negedge RST_IN) begin
        if (!RST_IN) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign SYNC_OUT = chain_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/rst_seq.sv
// ============================================================================
// rst_seq : synchronizes an external reset, holds all domain resets for a
//           minimum time, then releases them one by one in index order.
// Rev 1.0
// ============================================================================
`default_nettype none

module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int NUM_OUT     = DEF_NUM_OUT,
    parameter int MIN_HOLD    = DEF_MIN_HOLD,
    parameter int STAGE_GAP   = DEF_STAGE_GAP
) (
    input  logic               CLK,
    input  logic               RST_IN,
    input  logic               SW_RST,
    output logic [NUM_OUT-1:0] RST_OUT,
    output logic               RST_DONE
);

    localparam int            CW       = cnt_width(MIN_HOLD, STAGE_GAP);
    localparam logic [CW-1:0] HOLD_END = CW'(MIN_HOLD);
    localparam logic [CW-1:0] GAP_END  = CW'(STAGE_GAP);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
            $error("rst_seq: SYNC_STAGES out of range 2..4");
        end
        if (NUM_OUT < 1 || NUM_OUT > 8) begin : g_bad_num_out
            $error("rst_seq: NUM_OUT out of range 1..8");
        end
        if (MIN_HOLD < 1 || MIN_HOLD > 255) begin : g_bad_min_hold
            $error("rst_seq: MIN_HOLD out of range 1..255");
        end
        if (STAGE_GAP < 1 || STAGE_GAP > 255) begin : g_bad_stage_gap
            $error("rst_seq: STAGE_GAP out of range 1..255");
        end
    endgenerate

    logic               rst_sync;
    state_t             state_q, state_d;
    logic [CW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [CW-1:0]      gap_cnt_q, gap_cnt_d;
    logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
    logic [CW-1:0]      hold_inc;
    logic [CW-1:0]      gap_inc;
    logic [NUM_OUT-1:0] out_next;

    rst_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK      (CLK),
        .RST_IN   (RST_IN),
        .SYNC_OUT (rst_sync)
    );

    assign hold_inc = hold_cnt_q + CW'(1);
    assign gap_inc  = gap_cnt_q + CW'(1);
    // Thermometer step: releases the lowest still-asserted output.
    assign out_next = (rst_out_q << 1) | NUM_OUT'(1);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rst_out_d  = rst_out_q;
        case (state_q)
            HOLD: begin
                if (SW_RST) begin
                    hold_cnt_d = '0;
                end else if (rst_sync) begin
                    if (hold_inc == HOLD_END) begin
                        hold_cnt_d = '0;
                        rst_out_d  = NUM_OUT'(1);
                        state_d    = (NUM_OUT == 1) ? RUN : SEQ;
                    end else begin
                        hold_cnt_d = hold_inc;
                    end
                end
            end
            SEQ: begin
                if (SW_RST) begin
                    state_d   = HOLD;
                    gap_cnt_d = '0;
                    rst_out_d = '0;
                end else if (gap_inc == GAP_END) begin
                    gap_cnt_d = '0;
                    rst_out_d = out_next;
                    if (&out_next) begin
                        state_d = RUN;
                    end
                end else begin
                    gap_cnt_d = gap_inc;
                end
            end
            RUN: begin
                if (SW_RST) begin
                    state_d   = HOLD;
                    rst_out_d = '0;
                end
            end
            default: begin
                state_d    = HOLD;
                hold_cnt_d = '0;
                gap_cnt_d  = '0;
                rst_out_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_IN) begin
        if (!RST_IN) begin
            state_q    <= HOLD;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            rst_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            rst_out_q  <= rst_out_d;
        end
    end

    assign RST_OUT  = rst_out_q;
    assign RST_DONE = &rst_out_q;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq.sv
// ============================================================================
// tb_rst_seq : self-checking bench for rst_seq (default build plus a minimal
//              single-output build).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rst_seq;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst_a, sw_a, rst_b, sw_b;
    logic [3:0] out_a;
    logic       done_a;
    logic [0:0] out_b;
    logic       done_b;

    rst_seq dut_a (
        .CLK      (CLK),
        .RST_IN   (rst_a),
        .SW_RST   (sw_a),
        .RST_OUT  (out_a),
        .RST_DONE (done_a)
    );

    rst_seq #(
        .SYNC_STAGES (3),
        .NUM_OUT     (1),
        .MIN_HOLD    (1),
        .STAGE_GAP   (1)
    ) dut_b (
        .CLK      (CLK),
        .RST_IN   (rst_b),
        .SW_RST   (sw_b),
        .RST_OUT  (out_b),
        .RST_DONE (done_b)
    );

    typedef struct packed {
        logic [3:0] out;
        logic       done;
    } exp_t;

    typedef struct {
        int         edge_n;
        logic [3:0] out;
        logic       done;
    } vec_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Expected release pattern: bit k is released from edge first+4*k onward.
    function automatic logic [3:0] therm(input int e, input int first);
        logic [3:0] v;
        for (int k = 0; k < 4; k++) begin
            v[k] = (e >= first + 4 * k);
        end
        return v;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic check_now(input string nm, input logic [3:0] eo, input logic ed);
        cmp({nm, "_out"}, int'(out_a), int'(eo));
        cmp({nm, "_done"}, int'(done_a), int'(ed));
    endtask

    task automatic edge_check(input string nm, input logic [3:0] eo, input logic ed);
        exp_t e;
        sbq.push_back('{out: eo, done: ed});
        @(posedge CLK);
        #1;
        e = sbq.pop_front();
        cmp({nm, "_out"}, int'(out_a), int'(e.out));
        cmp({nm, "_done"}, int'(done_a), int'(e.done));
    endtask

    initial begin
        vec_t       tbl[9];
        logic [3:0] eo;
        logic       ed;

        tbl[0] = '{1,  4'b0000, 1'b0};
        tbl[1] = '{10, 4'b0001, 1'b0};
        tbl[2] = '{13, 4'b0001, 1'b0};
        tbl[3] = '{14, 4'b0011, 1'b0};
        tbl[4] = '{17, 4'b0011, 1'b0};
        tbl[5] = '{18, 4'b0111, 1'b0};
        tbl[6] = '{21, 4'b0111, 1'b0};
        tbl[7] = '{22, 4'b1111, 1'b1};
        tbl[8] = '{26, 4'b1111, 1'b1};

        rst_a = 1'b0;
        rst_b = 1'b0;
        sw_a  = 1'b0;
        sw_b  = 1'b0;
        #1;
        check_now("reset_async", 4'b0000, 1'b0);
        cmp("b_reset_out", int'(out_b), 0);
        for (int i = 0; i < 5; i++) edge_check("in_reset", 4'b0000, 1'b0);

        // Power-on release: next rising edge is E1.
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int e = 1; e <= 28; e++) begin
            eo = tbl[0].out;
            ed = tbl[0].done;
            for (int t = 0; t < 9; t++) begin
                if (tbl[t].edge_n <= e) begin
                    eo = tbl[t].out;
                    ed = tbl[t].done;
                end
            end
            edge_check($sformatf("poweron_e%0d", e), eo, ed);
            cmp($sformatf("b_out_e%0d", e), int'(out_b), (e >= 4) ? 1 : 0);
            cmp($sformatf("b_done_e%0d", e), int'(done_b), (e >= 4) ? 1 : 0);
        end

        // Short RST_IN glitch between edges while in RUN.
        #2 rst_a = 1'b0;
        #1 check_now("glitch_async", 4'b0000, 1'b0);
        #1 rst_a = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            eo = therm(e, 10);
            edge_check($sformatf("glitch_e%0d", e), eo, &eo);
        end

        // RST_IN drop mid-sequence after edge 16.
        rst_a = 1'b0;
        #1 check_now("seq_prep", 4'b0000, 1'b0);
        edge_check("seq_prep_hold", 4'b0000, 1'b0);
        rst_a = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            eo = therm(e, 10);
            edge_check($sformatf("seqrun_e%0d", e), eo, &eo);
        end
        #2 rst_a = 1'b0;
        #1 check_now("seq_abort_async", 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) edge_check("seq_abort_hold", 4'b0000, 1'b0);
        rst_a = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            eo = therm(e, 10);
            edge_check($sformatf("seq_restart_e%0d", e), eo, &eo);
        end

        // Software reset for three edges while in RUN.
        sw_a = 1'b1;
        for (int i = 0; i < 3; i++) edge_check($sformatf("sw_run_%0d", i), 4'b0000, 1'b0);
        sw_a = 1'b0;
        for (int j = 0; j <= 22; j++) begin
            eo = therm(j, 7);
            edge_check($sformatf("sw_after_A%0d", j), eo, &eo);
        end

        // One-edge software reset during HOLD when the count is 5.
        rst_a = 1'b0;
        edge_check("hold_prep", 4'b0000, 1'b0);
        rst_a = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            sw_a = (e == 8);
            eo   = therm(e, 16);
            edge_check($sformatf("sw_hold_e%0d", e), eo, &eo);
        end
        sw_a = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
